// File: rtl/reg_file_sb.sv
// Register file with a scoreboard of pending writebacks. After reset a CLEAR
// sweep zeroes every register and pending bit before the block reports ready.
module reg_file_sb #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            pend_set,
  input  logic [AW-1:0]   pend_addr,
  output logic            busy1,
  output logic            busy2,
  output logic            ready
);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e          r_state;
  logic [AW-1:0]   r_clr_idx;
  logic            r_ready;
  logic [XLEN-1:0] r_regs [NREGS];
  logic [NREGS-1:0] r_pend;

  logic w_run;
  logic w_wr;
  logic w_ps;
  logic w_hit1;
  logic w_hit2;

  // Gating with rst_n keeps the outputs in their CLEAR values while reset is held.
  assign w_run  = rst_n && (r_state == StRun);
  assign w_wr   = w_run && we && (waddr != '0);
  assign w_ps   = w_run && pend_set && (pend_addr != '0);
  assign w_hit1 = w_wr && (waddr == raddr1);
  assign w_hit2 = w_wr && (waddr == raddr2);
  assign ready  = r_ready && rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= StClear;
      r_clr_idx <= '0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        StClear: begin
          r_regs[r_clr_idx] <= '0;
          r_pend[r_clr_idx] <= 1'b0;
          r_clr_idx         <= r_clr_idx + AW'(1);
          if (r_clr_idx == AW'(NREGS - 1)) begin
            r_state <= StRun;
            r_ready <= 1'b1;
          end
        end
        StRun: begin
          if (w_wr) begin
            r_regs[waddr] <= wdata;
            r_pend[waddr] <= 1'b0;
          end
          // Issued after the write clears it: a same-cycle re-issue keeps the bit set.
          if (w_ps) begin
            r_pend[pend_addr] <= 1'b1;
          end
        end
        default: begin
          r_state <= StClear;
        end
      endcase
    end
  end

  always_comb begin
    rd1   = '0;
    busy1 = 1'b1;
    if (w_run) begin
      busy1 = 1'b0;
      if (raddr1 != '0) begin
        rd1   = w_hit1 ? wdata : r_regs[raddr1];
        busy1 = r_pend[raddr1] && !w_hit1;
      end
    end
  end

  always_comb begin
    rd2   = '0;
    busy2 = 1'b1;
    if (w_run) begin
      busy2 = 1'b0;
      if (raddr2 != '0) begin
        rd2   = w_hit2 ? wdata : r_regs[raddr2];
        busy2 = r_pend[raddr2] && !w_hit2;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: clear sequence, bypass, x0, scoreboard and
// reset during an in-progress clear.
module tb_reg_file_sb;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;

  logic            clk;
  logic            rst_n;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [XLEN-1:0] wdata;
  logic [AW-1:0]   raddr1;
  logic [AW-1:0]   raddr2;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic            pend_set;
  logic [AW-1:0]   pend_addr;
  logic            busy1;
  logic            busy2;
  logic            ready;

  int n_vec;
  int n_err;

  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr1    (raddr1),
    .raddr2    (raddr2),
    .rd1       (rd1),
    .rd2       (rd2),
    .pend_set  (pend_set),
    .pend_addr (pend_addr),
    .busy1     (busy1),
    .busy2     (busy2),
    .ready     (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; checks follow 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    raddr1 = 5'd3; raddr2 = 5'd4; pend_set = 1'b0; pend_addr = '0;
    #1;
    n_vec++;
    if ({ready, busy1, busy2, rd1, rd2} !== {1'b0, 1'b1, 1'b1, 64'h0}) begin
      n_err++;
      $display("FAIL reset_hold: ready=%b busy=%b%b rd1=%h rd2=%h want 0 11 0 0",
               ready, busy1, busy2, rd1, rd2);
    end
    tick(); tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      #1;
      n_vec++;
      if ({ready, busy1, rd1} !== {1'b0, 1'b1, 32'h0}) begin
        n_err++;
        $display("FAIL clear_cycle%0d: ready=%b busy1=%b rd1=%h want 0 1 0",
                 i, ready, busy1, rd1);
      end
      tick();
    end
    n_vec++;
    if (ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_rise: ready=%b want 1", ready);
    end
    for (int r = 0; r < 32; r++) begin
      raddr1 = 5'(r);
      raddr2 = 5'(31 - r);
      #1;
      n_vec++;
      if ({rd1, rd2, busy1, busy2} !== {64'h0, 2'b00}) begin
        n_err++;
        $display("FAIL cleared_x%0d: rd1=%h rd2=%h busy=%b%b want 0 0 00",
                 r, rd1, rd2, busy1, busy2);
      end
    end
    tick();
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr1 = 5'd5; raddr2 = 5'd5;
    #1;
    n_vec++;
    if ({rd1, rd2} !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL bypass: rd1=%h rd2=%h want deadbeef", rd1, rd2);
    end
    tick();
    we = 1'b1; waddr = 5'd3; wdata = 32'h0000_1111;
    #1;
    n_vec++;
    if ({rd1, rd2} !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL stored_x5: rd1=%h rd2=%h want deadbeef", rd1, rd2);
    end
    tick();
    we = 1'b0; raddr1 = 5'd3; raddr2 = 5'd5;
    #1;
    n_vec++;
    if ({rd1, rd2} !== {32'h0000_1111, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL dual_port: rd1=%h rd2=%h want 00001111 deadbeef", rd1, rd2);
    end
    tick();
  endtask

  task automatic test_x0();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    pend_set = 1'b1; pend_addr = 5'd0; raddr1 = 5'd0; raddr2 = 5'd0;
    #1;
    n_vec++;
    if ({rd1, busy1, busy2} !== {32'h0, 2'b00}) begin
      n_err++;
      $display("FAIL x0_same_cycle: rd1=%h busy=%b%b want 0 00", rd1, busy1, busy2);
    end
    tick();
    we = 1'b0; pend_set = 1'b0;
    #1;
    n_vec++;
    if ({rd1, rd2, busy1} !== {64'h0, 1'b0}) begin
      n_err++;
      $display("FAIL x0_after: rd1=%h rd2=%h busy1=%b want 0 0 0", rd1, rd2, busy1);
    end
    tick();
  endtask

  task automatic test_pending();
    raddr1 = 5'd7; raddr2 = 5'd7;
    pend_set = 1'b1; pend_addr = 5'd7;
    #1;
    n_vec++;
    if (busy1 !== 1'b0) begin
      n_err++;
      $display("FAIL pend_issue_cycle: busy1=%b want 0", busy1);
    end
    tick();
    pend_set = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if ({busy1, busy2} !== 2'b11) begin
        n_err++;
        $display("FAIL pend_wait%0d: busy=%b%b want 11", i, busy1, busy2);
      end
      tick();
    end
    we = 1'b1; waddr = 5'd7; wdata = 32'h12;
    #1;
    n_vec++;
    if ({busy1, rd1} !== {1'b0, 32'h12}) begin
      n_err++;
      $display("FAIL pend_wb_cycle: busy1=%b rd1=%h want 0 12", busy1, rd1);
    end
    tick();
    we = 1'b0;
    #1;
    n_vec++;
    if ({busy1, busy2, rd1} !== {2'b00, 32'h12}) begin
      n_err++;
      $display("FAIL pend_wb_after: busy=%b%b rd1=%h want 00 12", busy1, busy2, rd1);
    end
    tick();
    we = 1'b1; wdata = 32'h34; pend_set = 1'b1; pend_addr = 5'd7;
    tick();
    we = 1'b0; pend_set = 1'b0;
    #1;
    n_vec++;
    if ({busy1, rd1} !== {1'b1, 32'h34}) begin
      n_err++;
      $display("FAIL pend_same_cycle: busy1=%b rd1=%h want 1 34", busy1, rd1);
    end
    we = 1'b1; wdata = 32'h56;
    tick();
    we = 1'b0;
    #1;
    n_vec++;
    if (busy1 !== 1'b0) begin
      n_err++;
      $display("FAIL pend_reclear: busy1=%b want 0", busy1);
    end
    tick();
  endtask

  task automatic test_reset_midclear();
    we = 1'b1; waddr = 5'd9; wdata = 32'hA5; raddr1 = 5'd9; raddr2 = 5'd9;
    tick();
    we = 1'b0;
    #1;
    n_vec++;
    if (rd1 !== 32'hA5) begin
      n_err++;
      $display("FAIL x9_written: rd1=%h want a5", rd1);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({ready, busy1, rd1} !== {1'b0, 1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL midclear_hold: ready=%b busy1=%b rd1=%h want 0 1 0", ready, busy1, rd1);
    end
    tick();
    rst_n = 1'b1;
    we = 1'b1; waddr = 5'd9; wdata = 32'h55; pend_set = 1'b1; pend_addr = 5'd9;
    for (int i = 0; i < 32; i++) begin
      #1;
      n_vec++;
      if ({ready, rd1} !== {1'b0, 32'h0}) begin
        n_err++;
        $display("FAIL reclear_cycle%0d: ready=%b rd1=%h want 0 0", i, ready, rd1);
      end
      tick();
    end
    we = 1'b0; pend_set = 1'b0;
    #1;
    n_vec++;
    if ({ready, rd1, busy1} !== {1'b1, 32'h0, 1'b0}) begin
      n_err++;
      $display("FAIL reclear_done: ready=%b rd1=%h busy1=%b want 1 0 0", ready, rd1, busy1);
    end
    raddr1 = 5'd5;
    #1;
    n_vec++;
    if (rd1 !== 32'h0) begin
      n_err++;
      $display("FAIL reclear_x5: rd1=%h want 0", rd1);
    end
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_bypass();
    test_x0();
    test_pending();
    test_reset_midclear();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of each register in bits.
REQ-002 SHALL have parameter NREGS, default 32, number of architectural registers (power of two, >=2).
REQ-003 SHALL have derived localparam AW = clog2(NREGS), the register-address width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port we  input  1  write enable (writeback).
REQ-007 SHALL have port waddr  input  AW  write register index.
REQ-008 SHALL have port wdata  input  XLEN  write data.
REQ-009 SHALL have port raddr1  input  AW  read port 1 index.
REQ-010 SHALL have port raddr2  input  AW  read port 2 index.
REQ-011 SHALL have port rd1  output  XLEN  read port 1 data, combinational.
REQ-012 SHALL have port rd2  output  XLEN  read port 2 data, combinational.
REQ-013 SHALL have port pend_set  input  1  mark a destination register pending (instruction issued).
REQ-014 SHALL have port pend_addr  input  AW  register index marked pending.
REQ-015 SHALL have port busy1  output  1  raddr1 has an outstanding write.
REQ-016 SHALL have port busy2  output  1  raddr2 has an outstanding write.
REQ-017 SHALL have port ready  output  1  clear sequence complete; block accepts writes.

Function
REQ-018 SHALL implement a two-state FSM: CLEAR and RUN.
REQ-019 In CLEAR, a counter clr_idx SHALL write zero to register clr_idx and clear its pending bit each cycle, incrementing by 1.
REQ-020 CLEAR -> RUN SHALL occur on the edge where clr_idx == NREGS-1 is written; ready SHALL be 1 from the next cycle, i.e. exactly NREGS cycles after rst_n deasserts.
REQ-021 In CLEAR, we and pend_set SHALL be ignored, rd1/rd2 SHALL be 0, and busy1/busy2 SHALL be 1.
REQ-022 In RUN, we=1 with waddr != 0 SHALL write wdata to register waddr at the edge.
REQ-023 Register 0 SHALL always read 0; writes and pend_set targeting index 0 SHALL have no effect.
REQ-024 rdN SHALL equal wdata in the same cycle when we=1, waddr==raddrN, waddr != 0 and state is RUN (write-through bypass); otherwise rdN = stored value.
REQ-025 pend_set=1 (RUN, pend_addr != 0) SHALL set pending[pend_addr] at the edge.
REQ-026 we=1 (RUN, waddr != 0) SHALL clear pending[waddr] at the edge.
REQ-027 Simultaneous pend_set and we to the same index SHALL leave the bit set (new issue wins).
REQ-028 busyN SHALL be pending[raddrN] AND NOT (we AND waddr==raddrN AND waddr != 0) in RUN; busyN SHALL be 0 for raddrN == 0.
REQ-029 Both read ports SHALL be independent; raddr1 == raddr2 SHALL return identical data and busy.

Reset
REQ-030 rst_n=0 at an edge SHALL force state CLEAR, clr_idx=0, ready=0, regardless of any in-progress operation, including mid-CLEAR.
REQ-031 While rst_n=0, rd1=rd2=0, busy1=busy2=1, ready=0; the clear sequence SHALL begin on the first edge with rst_n=1.
REQ-032 Register contents and pending bits SHALL be defined solely by the clear sequence; no initial blocks SHALL be relied upon.

Verification
REQ-033 Reset then idle, NREGS=32 -> ready=0 for exactly 32 cycles after rst_n rises, then 1; all 32 registers read 0, busy=0.
REQ-034 RUN: we=1, waddr=5, wdata=0xDEADBEEF, raddr1=5 same cycle -> rd1=0xDEADBEEF combinationally; next cycle with we=0, rd1=0xDEADBEEF.
REQ-035 Write waddr=0, wdata=0xFFFFFFFF and pend_set to 0 -> rd1 at raddr1=0 stays 0, busy1=0.
REQ-036 pend_set on 7, then 3 cycles later we to 7 with 0x12 -> busy1 (raddr1=7) is 1 for those 3 cycles, 0 in the write cycle, stays 0 after, rd1=0x12; repeat with pend_set and we both on 7 in one cycle -> busy1=1 next cycle.
REQ-037 Assert rst_n=0 for one cycle after writing 0xA5 to x9 and mid-way (cycle 10) through a clear -> sequence restarts, ready rises 32 cycles after release, x9 reads 0, writes during CLEAR are dropped.
